// File: rtl/switch_debouncer.sv
// Per-channel switch conditioner: two-flop synchroniser, stability-counter debounce,
// registered clean level plus one-cycle press/release/changed pulses.
module switch_debouncer #(
  parameter int NUM_CHANNELS    = 4,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                    i_Clk,
  input  logic                    i_Reset,
  input  logic [NUM_CHANNELS-1:0] i_Switch,
  output logic [NUM_CHANNELS-1:0] o_Switch,
  output logic [NUM_CHANNELS-1:0] o_Pressed,
  output logic [NUM_CHANNELS-1:0] o_Released,
  output logic                    o_Changed
);

  localparam int CNT_WIDTH = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [NUM_CHANNELS-1:0] r_sync_p0;
  logic [NUM_CHANNELS-1:0] r_sync_p1;
  logic [NUM_CHANNELS-1:0] r_stable;
  logic [NUM_CHANNELS-1:0] r_pressed;
  logic [NUM_CHANNELS-1:0] r_released;
  logic                    r_changed;
  logic [CNT_WIDTH-1:0]    r_cnt [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0] w_mismatch;
  logic [NUM_CHANNELS-1:0] w_accept;

  // Any agreement with the stable level restarts the count; the count never passes CNT_MAX.
  function automatic logic [CNT_WIDTH-1:0] f_cnt_next(input logic [CNT_WIDTH-1:0] cnt,
                                                      input logic mismatch);
    if (!mismatch || (cnt == CNT_MAX))
      return '0;
    return cnt + 1'b1;
  endfunction

  assign w_mismatch = r_sync_p1 ^ r_stable;

  always_comb begin
    w_accept = '0;
    for (int i = 0; i < NUM_CHANNELS; i++)
      w_accept[i] = w_mismatch[i] && (r_cnt[i] == CNT_MAX);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      r_sync_p0  <= '0;
      r_sync_p1  <= '0;
      r_stable   <= '0;
      r_pressed  <= '0;
      r_released <= '0;
      r_changed  <= 1'b0;
      for (int i = 0; i < NUM_CHANNELS; i++)
        r_cnt[i] <= '0;
    end else begin
      // p0 -> p1: synchroniser; only p1 feeds the debounce logic
      r_sync_p0  <= i_Switch;
      r_sync_p1  <= r_sync_p0;
      for (int i = 0; i < NUM_CHANNELS; i++)
        r_cnt[i] <= f_cnt_next(r_cnt[i], w_mismatch[i]);
      // p1 -> outputs: level and pulses update on the same edge
      r_stable   <= r_stable ^ w_accept;
      r_pressed  <= w_accept & r_sync_p1;
      r_released <= w_accept & ~r_sync_p1;
      r_changed  <= |w_accept;
    end
  end

  assign o_Switch   = r_stable;
  assign o_Pressed  = r_pressed;
  assign o_Released = r_released;
  assign o_Changed  = r_changed;

endmodule

// File: tb/tb_switch_debouncer.sv
// Scoreboard bench for switch_debouncer with DEBOUNCE_CYCLES=4, NUM_CHANNELS=4.
module tb_switch_debouncer;

  localparam int NCH = 4;
  localparam int DEB = 4;
  localparam int LAT = DEB + 2;

  logic           i_Clk;
  logic           i_Reset;
  logic [NCH-1:0] i_Switch;
  logic [NCH-1:0] o_Switch;
  logic [NCH-1:0] o_Pressed;
  logic [NCH-1:0] o_Released;
  logic           o_Changed;

  switch_debouncer #(.NUM_CHANNELS(NCH), .DEBOUNCE_CYCLES(DEB)) dut (
    .i_Clk      (i_Clk),
    .i_Reset    (i_Reset),
    .i_Switch   (i_Switch),
    .o_Switch   (o_Switch),
    .o_Pressed  (o_Pressed),
    .o_Released (o_Released),
    .o_Changed  (o_Changed)
  );

  typedef struct {
    int             due;
    string          tag;
    logic [NCH-1:0] sw;
    logic [NCH-1:0] pr;
    logic [NCH-1:0] rl;
    logic           ch;
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt  = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  always @(posedge i_Clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s @cycle %0d: got %0h expected %0h", tag, cyc_cnt, obs, exp_v);
    end
  endtask

  always @(negedge i_Clk) begin
    while (exp_q.size() > 0 && exp_q[0].due <= cyc_cnt) begin
      exp_t e;
      e = exp_q.pop_front();
      chk({e.tag, ".switch"},   32'(o_Switch),   32'(e.sw));
      chk({e.tag, ".pressed"},  32'(o_Pressed),  32'(e.pr));
      chk({e.tag, ".released"}, 32'(o_Released), 32'(e.rl));
      chk({e.tag, ".changed"},  32'(o_Changed),  32'(e.ch));
    end
  end

  // Drive one cycle of stimulus and queue the outputs expected after the next edge.
  task automatic cyc(input logic [NCH-1:0] sw, input logic rst,
                     input logic [NCH-1:0] esw, input logic [NCH-1:0] epr,
                     input logic [NCH-1:0] erl, input logic ech, input string tag);
    exp_t e;
    @(posedge i_Clk);
    #2;
    i_Switch = sw;
    i_Reset  = rst;
    e.due = cyc_cnt + 1;
    e.tag = tag;
    e.sw  = esw;
    e.pr  = epr;
    e.rl  = erl;
    e.ch  = ech;
    exp_q.push_back(e);
  endtask

  // Hold a level for n cycles: old level for LAT-1 edges, new level with pulses on edge LAT.
  task automatic hold(input logic [NCH-1:0] sw, input int n,
                      input logic [NCH-1:0] esw0, input logic [NCH-1:0] esw1,
                      input logic [NCH-1:0] epr, input logic [NCH-1:0] erl,
                      input string tag);
    for (int i = 1; i <= n; i++) begin
      if (i < LAT)
        cyc(sw, 1'b0, esw0, '0, '0, 1'b0, tag);
      else if (i == LAT)
        cyc(sw, 1'b0, esw1, epr, erl, |(epr | erl), tag);
      else
        cyc(sw, 1'b0, esw1, '0, '0, 1'b0, tag);
    end
  endtask

  logic [NCH-1:0] bounce [7];

  initial begin
    i_Reset  = 1'b1;
    i_Switch = '0;
    bounce   = '{4'b0011, 4'b0011, 4'b0011, 4'b0001, 4'b0011, 4'b0011, 4'b0001};

    // 1: reset with all switches high, then accept all four
    for (int i = 0; i < 3; i++)
      cyc(4'hF, 1'b1, '0, '0, '0, 1'b0, "t1_reset");
    hold(4'hF, 8, 4'h0, 4'hF, 4'hF, 4'h0, "t1_accept");
    hold(4'h0, 8, 4'hF, 4'h0, 4'h0, 4'hF, "t1_release");

    // 2: single channel press
    hold(4'b0001, 8, 4'b0000, 4'b0001, 4'b0001, 4'b0000, "t2_press0");

    // 3: channel 1 bounce, accepted LAT edges after final rise
    for (int i = 0; i < 7; i++)
      cyc(bounce[i], 1'b0, 4'b0001, '0, '0, 1'b0, "t3_bounce");
    hold(4'b0011, 9, 4'b0001, 4'b0011, 4'b0010, 4'b0000, "t3_settle");
    hold(4'b0001, 8, 4'b0011, 4'b0001, 4'b0000, 4'b0010, "t3_rel1");

    // 4: channel 0 release
    hold(4'b0000, 8, 4'b0001, 4'b0000, 4'b0000, 4'b0001, "t4_release0");

    // 5: two channels accepted together
    hold(4'b1010, 8, 4'b0000, 4'b1010, 4'b1010, 4'b0000, "t5_multi");
    hold(4'b0000, 8, 4'b1010, 4'b0000, 4'b0000, 4'b1010, "t5_clear");

    // 6: reset pulse mid-count discards progress
    for (int i = 0; i < 4; i++)
      cyc(4'b0100, 1'b0, '0, '0, '0, 1'b0, "t6_count");
    cyc(4'b0100, 1'b1, '0, '0, '0, 1'b0, "t6_reset");
    hold(4'b0100, 8, 4'b0000, 4'b0100, 4'b0100, 4'b0000, "t6_reaccept");

    repeat (3) @(negedge i_Clk);
    chk("scoreboard_drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
